// File: rtl/vtg_pkg.sv
// Shared timing defaults and helpers for the video timing generator.
// Colour-bar constants serve the optional VTG_COLORBAR_EN build.
package vtg_pkg;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 40;
    localparam int DEF_H_SYNC   = 48;
    localparam int DEF_H_BP     = 40;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 13;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BP     = 29;

    localparam int H_CNT_W = 11;
    localparam int V_CNT_W = 10;

    localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
    localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
    localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] RGB_RED     = 24'hFF0000;
    localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
    localparam logic [23:0] RGB_BLACK   = 24'h000000;

    function automatic int calc_h_total(
        input int active,
        input int fp,
        input int sync,
        input int bp
    );
        return active + fp + sync + bp;
    endfunction

    function automatic int calc_v_total(
        input int active,
        input int fp,
        input int sync,
        input int bp
    );
        return active + fp + sync + bp;
    endfunction

    function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
        logic [23:0] rgb;
        rgb = RGB_BLACK;
        unique case (idx)
            3'd0: rgb = RGB_WHITE;
            3'd1: rgb = RGB_YELLOW;
            3'd2: rgb = RGB_CYAN;
            3'd3: rgb = RGB_GREEN;
            3'd4: rgb = RGB_MAGENTA;
            3'd5: rgb = RGB_RED;
            3'd6: rgb = RGB_BLUE;
            3'd7: rgb = RGB_BLACK;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/vtg_axis_counter.sv
// One raster axis: wrapping counter plus active/sync region decode.
// Flags are combinational decodes of the current count.
module vtg_axis_counter
    import vtg_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter int W      = H_CNT_W
) (
    input  logic         i_clk,
    input  logic         i_res_n,
    input  logic         step,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic         active,
    output logic         sync
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_END = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_LO = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_HI = W'(ACTIVE + FP + SYNC - 1);

    // Advance on step, returning to zero after the last position.
    always_ff @(posedge i_clk) begin
        if (!i_res_n) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

    assign wrap   = (cnt == LAST);
    assign active = (cnt < ACT_END);
    assign sync   = (cnt >= SYNC_LO) && (cnt <= SYNC_HI);

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: syncs, data-enable and pixel coordinates.
// Optional colour-bar output o_rgb when VTG_COLORBAR_EN is defined.
module video_timing_gen
    import vtg_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic         i_clk,
    input  logic         i_res_n,
    input  logic         i_en,
    output logic         o_hsync,
    output logic         o_vsync,
    output logic         o_de,
    output logic [10:0]  o_x,
    output logic [9:0]   o_y,
    output logic         o_line_start,
    output logic         o_frame_start
`ifdef VTG_COLORBAR_EN
    ,
    output logic [23:0]  o_rgb
`endif
);

    localparam int H_TOTAL =
        calc_h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL =
        calc_v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > 2048) begin : g_h_total_err
        $error("H_TOTAL exceeds 2048");
    end
    if (V_TOTAL > 1024) begin : g_v_total_err
        $error("V_TOTAL exceeds 1024");
    end
    if (H_ACTIVE < 1 || H_FP < 1 ||
        H_SYNC < 1 || H_BP < 1) begin : g_h_par_err
        $error("horizontal timing values must be >= 1");
    end
    if (V_ACTIVE < 1 || V_FP < 1 ||
        V_SYNC < 1 || V_BP < 1) begin : g_v_par_err
        $error("vertical timing values must be >= 1");
    end

    logic [H_CNT_W-1:0] h_cnt;
    logic [V_CNT_W-1:0] v_cnt;
    logic               h_wrap;
    logic               v_wrap;
    logic               h_act;
    logic               v_act;
    logic               h_sync;
    logic               v_sync;
    logic               v_step;

    // v moves only on the h wrap, so vsync is line-aligned.
    assign v_step = i_en & h_wrap;

    vtg_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .W      (H_CNT_W)
    ) u_h (
        .i_clk   (i_clk),
        .i_res_n (i_res_n),
        .step    (i_en),
        .cnt     (h_cnt),
        .wrap    (h_wrap),
        .active  (h_act),
        .sync    (h_sync)
    );

    vtg_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .W      (V_CNT_W)
    ) u_v (
        .i_clk   (i_clk),
        .i_res_n (i_res_n),
        .step    (v_step),
        .cnt     (v_cnt),
        .wrap    (v_wrap),
        .active  (v_act),
        .sync    (v_sync)
    );

    // Register the decode of the current position on enabled edges.
    // Pulses drop on stalled edges so they are never re-issued.
    always_ff @(posedge i_clk) begin
        if (!i_res_n) begin
            o_hsync       <= ~HS_POL;
            o_vsync       <= ~VS_POL;
            o_de          <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
        end else if (i_en) begin
            o_hsync       <= h_sync ? HS_POL : ~HS_POL;
            o_vsync       <= v_sync ? VS_POL : ~VS_POL;
            o_de          <= h_act & v_act;
            o_x           <= h_cnt;
            o_y           <= v_cnt;
            o_line_start  <= (h_cnt == '0);
            o_frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end else begin
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
        end
    end

`ifdef VTG_COLORBAR_EN
    logic [2:0] bar_idx;

    // Eight equal bars across the visible width.
    assign bar_idx =
        3'((32'(h_cnt) * 32'd8) / 32'(H_ACTIVE));

    // Colour registered alongside o_de; black outside the active area.
    always_ff @(posedge i_clk) begin
        if (!i_res_n) begin
            o_rgb <= '0;
        end else if (i_en) begin
            o_rgb <= (h_act & v_act) ? bar_rgb(bar_idx) : '0;
        end
    end
`else
    logic unused_wrap;
    assign unused_wrap = v_wrap;
`endif

`ifdef VTG_COLORBAR_EN
    logic unused_vwrap;
    assign unused_vwrap = v_wrap;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized bench for video_timing_gen: small and default geometries
// compared each cycle against a position-based raster model.
module tb_video_timing_gen;

    typedef struct packed {
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
    } geo_t;

    typedef struct packed {
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        de;
        logic [10:0] x;
        logic [9:0]  y;
        logic        ls;
        logic        fs;
    } exp_t;

    localparam geo_t GS = '{4, 1, 2, 1, 3, 1, 1, 1};
    localparam geo_t GD = '{800, 40, 48, 40, 480, 13, 3, 29};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic s_rst_n, s_en, d_rst_n, d_en;
    logic s_hs, s_vs, s_de, s_ls, s_fs;
    logic d_hs, d_vs, d_de, d_ls, d_fs;
    logic [10:0] s_x, d_x;
    logic [9:0]  s_y, d_y;
`ifdef VTG_COLORBAR_EN
    logic [23:0] s_rgb, d_rgb;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   s_pos, d_pos;
    exp_t s_exp, d_exp;
    exp_t s_obs, d_obs;

    video_timing_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HS_POL   (1'b0), .VS_POL (1'b0)
    ) dut_s (
        .i_clk         (clk),
        .i_res_n       (s_rst_n),
        .i_en          (s_en),
        .o_hsync       (s_hs),
        .o_vsync       (s_vs),
        .o_de          (s_de),
        .o_x           (s_x),
        .o_y           (s_y),
        .o_line_start  (s_ls),
        .o_frame_start (s_fs)
`ifdef VTG_COLORBAR_EN
        ,
        .o_rgb         (s_rgb)
`endif
    );

    video_timing_gen dut_d (
        .i_clk         (clk),
        .i_res_n       (d_rst_n),
        .i_en          (d_en),
        .o_hsync       (d_hs),
        .o_vsync       (d_vs),
        .o_de          (d_de),
        .o_x           (d_x),
        .o_y           (d_y),
        .o_line_start  (d_ls),
        .o_frame_start (d_fs)
`ifdef VTG_COLORBAR_EN
        ,
        .o_rgb         (d_rgb)
`endif
    );

    always_comb begin
        s_obs = '0;
        d_obs = '0;
        s_obs.hs = s_hs; s_obs.vs = s_vs; s_obs.de = s_de;
        s_obs.x  = s_x;  s_obs.y  = s_y;
        s_obs.ls = s_ls; s_obs.fs = s_fs;
        d_obs.hs = d_hs; d_obs.vs = d_vs; d_obs.de = d_de;
        d_obs.x  = d_x;  d_obs.y  = d_y;
        d_obs.ls = d_ls; d_obs.fs = d_fs;
`ifdef VTG_COLORBAR_EN
        s_obs.rgb = s_rgb;
        d_obs.rgb = d_rgb;
`endif
    end

    task automatic check(
        input string       tag,
        input logic [63:0] got,
        input logic [63:0] exp
    );
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] bar_color(input int i);
        case (i)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic exp_t rst_val();
        exp_t e;
        e = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        return e;
    endfunction

    // Expected outputs for raster position pos (pixel index in frame).
    function automatic exp_t decode(input int pos, input geo_t g);
        exp_t e;
        int ht, vt, x, y;
        ht = g.ha + g.hf + g.hs + g.hb;
        vt = g.va + g.vf + g.vs + g.vb;
        x = pos % ht;
        y = (pos / ht) % vt;
        e = '0;
        e.x  = 11'(x);
        e.y  = 10'(y);
        e.hs = !(x >= g.ha + g.hf && x < g.ha + g.hf + g.hs);
        e.vs = !(y >= g.va + g.vf && y < g.va + g.vf + g.vs);
        e.de = (x < g.ha) && (y < g.va);
        e.ls = (x == 0);
        e.fs = (x == 0) && (y == 0);
`ifdef VTG_COLORBAR_EN
        if (e.de) e.rgb = bar_color((x * 8) / g.ha);
`endif
        return e;
    endfunction

    function automatic exp_t model_out(
        input exp_t prev, input int pos,
        input logic rst_n, input logic en, input geo_t g
    );
        exp_t e;
        if (!rst_n) begin
            e = rst_val();
        end else if (en) begin
            e = decode(pos, g);
        end else begin
            e = prev;
            e.ls = 1'b0;
            e.fs = 1'b0;
        end
        return e;
    endfunction

    function automatic int next_pos(
        input int pos, input logic rst_n,
        input logic en, input geo_t g
    );
        int frame;
        frame = (g.ha + g.hf + g.hs + g.hb) *
                (g.va + g.vf + g.vs + g.vb);
        if (!rst_n) return 0;
        if (en) return (pos + 1) % frame;
        return pos;
    endfunction

    task automatic tick();
        @(posedge clk);
        s_exp = model_out(s_exp, s_pos, s_rst_n, s_en, GS);
        s_pos = next_pos(s_pos, s_rst_n, s_en, GS);
        d_exp = model_out(d_exp, d_pos, d_rst_n, d_en, GD);
        d_pos = next_pos(d_pos, d_rst_n, d_en, GD);
        cyc++;
        #1;
        check("small", 64'(s_obs), 64'(s_exp));
        check("dflt", 64'(d_obs), 64'(d_exp));
    endtask

    initial begin
        exp_t first;
        int   fs_t[$];
        int   ls_t[$];
        int   de_cnt, hs_lo, vs_lo, dbl, ls_cnt;
        logic prev_ls;
        bit   hit;

        s_rst_n = 1'b0; s_en = 1'b1;
        d_rst_n = 1'b0; d_en = 1'b1;
        s_pos = 0; d_pos = 0;
        s_exp = rst_val(); d_exp = rst_val();

        repeat (5) tick();
        check("rst_state", 64'(d_obs), 64'(rst_val()));

        s_rst_n = 1'b1; d_rst_n = 1'b1;
        tick();
        first = '0;
        first.hs = 1'b1; first.vs = 1'b1; first.de = 1'b1;
        first.ls = 1'b1; first.fs = 1'b1;
`ifdef VTG_COLORBAR_EN
        first.rgb = 24'hFFFFFF;
`endif
        check("first_out", 64'(d_obs), 64'(first));
        check("first_out_s", 64'(s_obs), 64'(first));

        de_cnt = 0; hs_lo = 0; vs_lo = 0;
        for (int i = 0; i < 110; i++) begin
            tick();
            if (s_fs) fs_t.push_back(cyc);
            if (fs_t.size() == 1) begin
                de_cnt += int'(s_de);
                hs_lo  += int'(!s_hs);
                vs_lo  += int'(!s_vs);
            end
        end
        check("fs_count", 64'(fs_t.size()), 64'(2));
        if (fs_t.size() >= 2)
            check("fs_period", 64'(fs_t[1] - fs_t[0]), 64'(48));
        check("de_per_frame", 64'(de_cnt), 64'(12));
        check("hs_lo_frame", 64'(hs_lo), 64'(12));
        check("vs_lo_frame", 64'(vs_lo), 64'(8));

        dbl = 0; prev_ls = 1'b0;
        for (int i = 0; i < 200; i++) begin
            s_en = (i % 2 == 0);
            tick();
            if (s_ls && prev_ls) dbl++;
            prev_ls = s_ls;
        end
        check("no_dup_pulse", 64'(dbl), 64'(0));

        for (int i = 0; i < 300; i++) begin
            s_en = ($urandom_range(0, 3) != 0);
            d_en = ($urandom_range(0, 1) != 0);
            tick();
        end

        s_en = 1'b1; d_en = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            tick();
            hit = (s_exp.x == 11'd3) && (s_exp.y == 10'd2);
        end
        check("reach_s", 64'(hit), 64'(1));
        s_rst_n = 1'b0;
        tick();
        check("midrst_s", 64'(s_obs), 64'(rst_val()));
        s_rst_n = 1'b1;
        tick();
        check("restart_s", 64'({s_x, s_y, s_fs}), 64'({21'd0, 1'b1}));

        hit = 1'b0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            tick();
            hit = (d_exp.x == 11'd300);
        end
        check("reach_d", 64'(hit), 64'(1));
        d_rst_n = 1'b0;
        tick();
        check("midrst_d", 64'(d_obs), 64'(rst_val()));
        d_rst_n = 1'b1;
        tick();
        check("restart_d", 64'({d_x, d_y, d_fs}), 64'({21'd0, 1'b1}));

        ls_cnt = 0; de_cnt = 0;
        for (int i = 0; i < 2784; i++) begin
            tick();
            if (d_ls) begin
                ls_cnt++;
                ls_t.push_back(cyc);
            end
            de_cnt += int'(d_de);
`ifdef VTG_COLORBAR_EN
            if (d_exp.x == 11'd0)
                check("bar_x0", 64'(d_rgb), 64'(24'hFFFFFF));
            if (d_exp.x == 11'd200)
                check("bar_x200", 64'(d_rgb), 64'(24'h00FFFF));
            if (d_exp.x == 11'd799)
                check("bar_x799", 64'(d_rgb), 64'(24'h000000));
            if (d_exp.x == 11'd800)
                check("bar_x800", 64'(d_rgb), 64'(24'h000000));
`endif
        end
        check("ls_count", 64'(ls_cnt), 64'(3));
        if (ls_t.size() >= 2)
            check("ls_period", 64'(ls_t[1] - ls_t[0]), 64'(928));
        check("de_3lines", 64'(de_cnt), 64'(2400));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
